// File: rtl/trap_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_entry_ctrl
// Purpose  : Sequences SPARC trap entry. It takes the trap type from the tt
//            encoder and then:
//              - updates PSR (ET=0, S=1, PS=old S, CWP=CWP-1 mod NWINDOWS)
//              - writes TBR = {TBA, tt, 4'b0000}
//              - saves PC/nPC into %l1/%l2 of the new window
//              - redirects fetch to the trap vector
//            A trap taken while ET=0 puts the block into a sticky error mode
//            that only reset clears.
// Ports    : clk, rst_n           - clock, async active-low reset
//            trap_req, tt_in      - trap request (level) and trap type
//            tba_in               - TBR.TBA field
//            pc_in, npc_in        - PC/nPC of the trapping instruction
//            psr_et, psr_s, cwp_in- current PSR fields
//            psr_we, et_out, s_out, ps_out, cwp_out - PSR write port
//            tbr_we, tbr_out      - TBR write port
//            rf_we, rf_addr, rf_data - register-file write port
//            redirect, redirect_pc   - fetch redirect
//            busy, error_mode        - status
// Revision : 1.0 - initial release
// ============================================================================
module trap_entry_ctrl #(
  parameter int NWINDOWS = 8,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [7:0]      tt_in,
  input  logic [19:0]     tba_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] npc_in,
  input  logic            psr_et,
  input  logic            psr_s,
  input  logic [4:0]      cwp_in,
  output logic            psr_we,
  output logic            et_out,
  output logic            s_out,
  output logic            ps_out,
  output logic [4:0]      cwp_out,
  output logic            tbr_we,
  output logic [31:0]     tbr_out,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [PC_W-1:0] rf_data,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            busy,
  output logic            error_mode
);

  localparam logic [4:0] c_CWP_LAST = 5'(NWINDOWS - 1);
  localparam logic [4:0] c_REG_L1   = 5'd17;
  localparam logic [4:0] c_REG_L2   = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WIN    = 3'd1,
    ST_SAVE1  = 3'd2,
    ST_SAVE2  = 3'd3,
    ST_VECTOR = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Trap context captured on acceptance
  logic [7:0]      tt_q,   tt_d;
  logic [PC_W-1:0] pc_q,   pc_d;
  logic [PC_W-1:0] npc_q,  npc_d;
  logic            ps_q,   ps_d;
  logic [4:0]      ncwp_q, ncwp_d;

  // Registered outputs
  logic            psr_we_q,      psr_we_d;
  logic            et_q,          et_d;
  logic            s_q,           s_d;
  logic            ps_out_q,      ps_out_d;
  logic [4:0]      cwp_out_q,     cwp_out_d;
  logic            tbr_we_q,      tbr_we_d;
  logic [31:0]     tbr_q,         tbr_d;
  logic            rf_we_q,       rf_we_d;
  logic [4:0]      rf_addr_q,     rf_addr_d;
  logic [PC_W-1:0] rf_data_q,     rf_data_d;
  logic            redirect_q,    redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            busy_q,        busy_d;
  logic            err_q,         err_d;

  always_comb begin
    state_d       = state_q;
    tt_d          = tt_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    ps_d          = ps_q;
    ncwp_d        = ncwp_q;
    psr_we_d      = 1'b0;
    tbr_we_d      = 1'b0;
    rf_we_d       = 1'b0;
    redirect_d    = 1'b0;
    et_d          = et_q;
    s_d           = s_q;
    ps_out_d      = ps_out_q;
    cwp_out_d     = cwp_out_q;
    tbr_d         = tbr_q;
    rf_addr_d     = rf_addr_q;
    rf_data_d     = rf_data_q;
    redirect_pc_d = redirect_pc_q;
    err_d         = err_q;
    // Outputs trail the state by one edge, so busy is derived from the
    // current state rather than the next one; it therefore drops one edge
    // after the redirect strobe.
    busy_d        = (state_q != ST_IDLE) && (state_q != ST_ERROR);

    case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          if (psr_et) begin
            state_d = ST_WIN;
            tt_d    = tt_in;
            pc_d    = pc_in;
            npc_d   = npc_in;
            ps_d    = psr_s;
            ncwp_d  = (cwp_in == 5'd0) ? c_CWP_LAST : (cwp_in - 5'd1);
          end else begin
            // Trap with traps disabled: no architectural writes at all
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_WIN: begin
        psr_we_d  = 1'b1;
        et_d      = 1'b0;
        s_d       = 1'b1;
        ps_out_d  = ps_q;
        cwp_out_d = ncwp_q;
        tbr_we_d  = 1'b1;
        // TBA is taken live here, not at acceptance
        tbr_d     = {tba_in, tt_q, 4'b0000};
        state_d   = ST_SAVE1;
      end
      ST_SAVE1: begin
        rf_we_d   = 1'b1;
        rf_addr_d = c_REG_L1;
        rf_data_d = pc_q;
        state_d   = ST_SAVE2;
      end
      ST_SAVE2: begin
        rf_we_d   = 1'b1;
        rf_addr_d = c_REG_L2;
        rf_data_d = npc_q;
        state_d   = ST_VECTOR;
      end
      ST_VECTOR: begin
        redirect_d    = 1'b1;
        redirect_pc_d = PC_W'(tbr_q);
        state_d       = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tt_q          <= '0;
      pc_q          <= '0;
      npc_q         <= '0;
      ps_q          <= 1'b0;
      ncwp_q        <= '0;
      psr_we_q      <= 1'b0;
      et_q          <= 1'b0;
      s_q           <= 1'b0;
      ps_out_q      <= 1'b0;
      cwp_out_q     <= '0;
      tbr_we_q      <= 1'b0;
      tbr_q         <= '0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tt_q          <= tt_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      ps_q          <= ps_d;
      ncwp_q        <= ncwp_d;
      psr_we_q      <= psr_we_d;
      et_q          <= et_d;
      s_q           <= s_d;
      ps_out_q      <= ps_out_d;
      cwp_out_q     <= cwp_out_d;
      tbr_we_q      <= tbr_we_d;
      tbr_q         <= tbr_d;
      rf_we_q       <= rf_we_d;
      rf_addr_q     <= rf_addr_d;
      rf_data_q     <= rf_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign psr_we      = psr_we_q;
  assign et_out      = et_q;
  assign s_out       = s_q;
  assign ps_out      = ps_out_q;
  assign cwp_out     = cwp_out_q;
  assign tbr_we      = tbr_we_q;
  assign tbr_out     = tbr_q;
  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = busy_q;
  assign error_mode  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_entry_ctrl
// Purpose  : Self-checking bench for trap_entry_ctrl. A reference model keeps
//            the edge index at which the current trap was accepted and derives
//            every expected strobe and held value from that schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_entry_ctrl;

  localparam int NW = 8;
  localparam int PW = 32;

  logic          clk;
  logic          rst_n;
  logic          trap_req;
  logic [7:0]    tt_in;
  logic [19:0]   tba_in;
  logic [PW-1:0] pc_in;
  logic [PW-1:0] npc_in;
  logic          psr_et;
  logic          psr_s;
  logic [4:0]    cwp_in;
  logic          psr_we;
  logic          et_out;
  logic          s_out;
  logic          ps_out;
  logic [4:0]    cwp_out;
  logic          tbr_we;
  logic [31:0]   tbr_out;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [PW-1:0] rf_data;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          busy;
  logic          error_mode;

  trap_entry_ctrl #(.NWINDOWS(NW), .PC_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trap_req   (trap_req),
    .tt_in      (tt_in),
    .tba_in     (tba_in),
    .pc_in      (pc_in),
    .npc_in     (npc_in),
    .psr_et     (psr_et),
    .psr_s      (psr_s),
    .cwp_in     (cwp_in),
    .psr_we     (psr_we),
    .et_out     (et_out),
    .s_out      (s_out),
    .ps_out     (ps_out),
    .cwp_out    (cwp_out),
    .tbr_we     (tbr_we),
    .tbr_out    (tbr_out),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .busy       (busy),
    .error_mode (error_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          edge_n;
  int          acc;        // edge index of the last accepted trap
  bit          m_err;
  logic [7:0]  m_tt;
  logic [31:0] m_pc, m_npc;
  bit          m_ps;
  logic [4:0]  m_ncwp;
  logic [31:0] m_tbr, m_redir_pc;
  logic [4:0]  m_cwp;
  bit          m_ps_out, m_et, m_s;

  task automatic model_reset();
    edge_n     = 0;
    acc        = -100;
    m_err      = 1'b0;
    m_tt       = '0;
    m_pc       = '0;
    m_npc      = '0;
    m_ps       = 1'b0;
    m_ncwp     = '0;
    m_tbr      = '0;
    m_redir_pc = '0;
    m_cwp      = '0;
    m_ps_out   = 1'b0;
    m_et       = 1'b0;
    m_s        = 1'b0;
  endtask

  // Advance one clock edge: update the model from the inputs currently
  // applied, then compare every output shortly after the edge.
  task automatic tick();
    int e;
    e = edge_n + 1;
    if (e == acc + 1) begin
      m_tbr    = {tba_in, m_tt, 4'h0};
      m_cwp    = m_ncwp;
      m_ps_out = m_ps;
      m_et     = 1'b0;
      m_s      = 1'b1;
    end
    if (e == acc + 4) m_redir_pc = m_tbr;
    if (!m_err && (e >= acc + 5) && trap_req) begin
      if (psr_et) begin
        acc    = e;
        m_tt   = tt_in;
        m_pc   = pc_in;
        m_npc  = npc_in;
        m_ps   = psr_s;
        m_ncwp = 5'((int'(cwp_in) + NW - 1) % NW);
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    edge_n = e;
    check("psr_we",      32'(psr_we),   32'(e == acc + 1));
    check("tbr_we",      32'(tbr_we),   32'(e == acc + 1));
    check("rf_we",       32'(rf_we),    32'((e == acc + 2) || (e == acc + 3)));
    check("redirect",    32'(redirect), 32'(e == acc + 4));
    check("busy",        32'(busy),     32'((e >= acc + 1) && (e <= acc + 4)));
    check("error_mode",  32'(error_mode), 32'(m_err));
    check("tbr_out",     tbr_out,       m_tbr);
    check("cwp_out",     32'(cwp_out),  32'(m_cwp));
    check("ps_out",      32'(ps_out),   32'(m_ps_out));
    check("et_out",      32'(et_out),   32'(m_et));
    check("s_out",       32'(s_out),    32'(m_s));
    check("redirect_pc", redirect_pc,   m_redir_pc);
    if (e == acc + 2) begin
      check("rf_addr_l1", 32'(rf_addr), 32'd17);
      check("rf_data_pc", rf_data,      m_pc);
    end
    if (e == acc + 3) begin
      check("rf_addr_l2", 32'(rf_addr), 32'd18);
      check("rf_data_npc", rf_data,     m_npc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_psr_we",   32'(psr_we),     32'd0);
    check("rst_tbr_we",   32'(tbr_we),     32'd0);
    check("rst_rf_we",    32'(rf_we),      32'd0);
    check("rst_redirect", 32'(redirect),   32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_error",    32'(error_mode), 32'd0);
    check("rst_tbr_out",  tbr_out,         32'd0);
    check("rst_cwp_out",  32'(cwp_out),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_trap(input logic [19:0] tba, input logic [7:0] tt,
                          input logic [31:0] pc, input logic [31:0] npc,
                          input logic [4:0] cwp, input logic s);
    tba_in   = tba;
    tt_in    = tt;
    pc_in    = pc;
    npc_in   = npc;
    cwp_in   = cwp;
    psr_s    = s;
    psr_et   = 1'b1;
    trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  int   psr_edges[$];
  logic [4:0] psr_cwps[$];

  initial begin
    rst_n    = 1'b1;
    trap_req = 1'b0;
    tt_in    = '0;
    tba_in   = '0;
    pc_in    = '0;
    npc_in   = '0;
    psr_et   = 1'b1;
    psr_s    = 1'b0;
    cwp_in   = '0;
    model_reset();
    #2;
    do_reset();
    tick();

    // Basic trap
    run_trap(20'h40000, 8'h05, 32'h100, 32'h104, 5'd3, 1'b0);
    check("basic_tbr_out",     tbr_out,          32'h40000050);
    check("basic_cwp_out",     32'(cwp_out),     32'd2);
    check("basic_redirect_pc", redirect_pc,      32'h40000050);

    // Busy ignore: a second request with a different tt during SAVE1
    tba_in = 20'h40000; tt_in = 8'h05; pc_in = 32'h200; npc_in = 32'h204;
    cwp_in = 5'd3; trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    tick();
    trap_req = 1'b1; tt_in = 8'h2A;
    tick();
    trap_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ignore_tbr_out", tbr_out, 32'h40000050);

    // CWP wrap and extreme tt values
    run_trap(20'h12345, 8'h00, 32'h300, 32'h304, 5'd0, 1'b1);
    check("wrap_cwp_out", 32'(cwp_out), 32'd7);
    run_trap(20'hFFFFF, 8'hFF, 32'hFFFF_FFFC, 32'h0, 5'd7, 1'b0);
    check("ttff_tbr_out", tbr_out, 32'hFFFFFFF0);

    // Back-to-back with trap_req held high
    tba_in = 20'h40000; tt_in = 8'h11; cwp_in = 5'd3; psr_s = 1'b1;
    trap_req = 1'b1;
    psr_edges.delete();
    psr_cwps.delete();
    tick();
    cwp_in = 5'd2;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (psr_we) begin
        psr_edges.push_back(edge_n);
        psr_cwps.push_back(cwp_out);
      end
    end
    trap_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("b2b_count", 32'(psr_edges.size()), 32'd2);
    if (psr_edges.size() == 2) begin
      check("b2b_gap",  32'(psr_edges[1] - psr_edges[0]), 32'd5);
      check("b2b_cwp0", 32'(psr_cwps[0]), 32'd2);
      check("b2b_cwp1", 32'(psr_cwps[1]), 32'd1);
    end

    // Reset in the middle of a sequence, then a full trap
    tba_in = 20'hABCDE; tt_in = 8'h33; trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    tick();
    do_reset();
    run_trap(20'h40000, 8'h05, 32'h100, 32'h104, 5'd3, 1'b0);

    // Randomized traffic (traps enabled)
    for (int i = 0; i < 400; i++) begin
      trap_req = ($urandom_range(0, 3) == 0);
      tt_in    = 8'($urandom);
      tba_in   = 20'($urandom);
      pc_in    = $urandom;
      npc_in   = $urandom;
      psr_s    = 1'($urandom);
      cwp_in   = 5'($urandom_range(0, NW - 1));
      psr_et   = 1'b1;
      tick();
    end
    trap_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Error mode: trap with ET=0, then more requests that must be ignored
    psr_et = 1'b0; trap_req = 1'b1; tt_in = 8'h07;
    tick();
    check("err_set", 32'(error_mode), 32'd1);
    for (int i = 0; i < 20; i++) begin
      trap_req = 1'($urandom);
      psr_et   = 1'($urandom);
      tt_in    = 8'($urandom);
      tick();
    end
    trap_req = 1'b0;
    psr_et   = 1'b1;
    do_reset();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_entry_ctrl.md
Name: trap_entry_ctrl

Overview:
- Consumes the 8-bit trap type produced by the tt encoder stage and sequences SPARC trap entry.
- Latches tt and PC/nPC, updates PSR fields (ET, S, PS, CWP), and writes TBR.
- Saves PC/nPC into the new window's locals %l1/%l2, then redirects fetch to the trap vector.
- Sits between the trap-type encoder and the PSR/TBR registers, register file write port and fetch unit.

Parameters:
NWINDOWS, 8, number of register windows; CWP wraps modulo NWINDOWS (2..32)
PC_W, 32, width of PC, nPC and redirect target

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
trap_req  input  1  trap request from upstream, level, sampled only in IDLE
tt_in  input  8  trap type from tt encoder, valid with trap_req
tba_in  input  20  TBR.TBA field
pc_in  input  PC_W  PC of trapping instruction
npc_in  input  PC_W  nPC of trapping instruction
psr_et  input  1  current PSR.ET
psr_s  input  1  current PSR.S
cwp_in  input  5  current PSR.CWP
psr_we  output  1  one-cycle strobe: write et_out/s_out/ps_out/cwp_out to PSR
et_out  output  1  new ET (always 0 on write)
s_out  output  1  new S (always 1 on write)
ps_out  output  1  new PS (old S)
cwp_out  output  5  new CWP
tbr_we  output  1  one-cycle strobe: write tbr_out to TBR
tbr_out  output  32  {tba_in, tt, 4'b0000}
rf_we  output  1  one-cycle register-file write strobe
rf_addr  output  5  window-relative register number (17 or 18)
rf_data  output  PC_W  data to write
redirect  output  1  one-cycle fetch redirect strobe
redirect_pc  output  PC_W  trap vector, equals tbr_out
busy  output  1  high in every state except IDLE and ERROR
error_mode  output  1  sticky; high once a trap is taken with ET=0

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All strobes, busy and error_mode go to 0.
  - tbr_out, cwp_out, rf_addr, rf_data, redirect_pc, et_out, s_out and ps_out go to 0.
  - Reset mid-sequence aborts with no further writes.
- States: IDLE, WIN, SAVE1, SAVE2, VECTOR, ERROR.
- IDLE:
  - trap_req=1 and psr_et=1 -> go WIN.
  - On that edge, latch tt=tt_in, pc=pc_in, npc=npc_in, ps=psr_s, and ncwp = (cwp_in==0) ? NWINDOWS-1 : cwp_in-1.
  - trap_req=1 and psr_et=0 -> go ERROR; error_mode=1 on the next edge.
- WIN (1 cycle):
  - psr_we=1, et_out=0, s_out=1, ps_out=latched ps, cwp_out=ncwp.
  - tbr_we=1, tbr_out={tba_in, tt, 4'b0}, with tba_in sampled this cycle.
  - Go SAVE1.
- SAVE1: rf_we=1, rf_addr=17, rf_data=latched pc; go SAVE2.
- SAVE2: rf_we=1, rf_addr=18, rf_data=latched npc; go VECTOR.
- VECTOR: redirect=1, redirect_pc=tbr_out; go IDLE.
- ERROR: terminal; no strobes; leaves only via reset.
- Strobe timing: each strobe is high for exactly one cycle per trap and only in the state listed. Outside those states, rf_we, psr_we, tbr_we and redirect are 0.
- Latency: trap_req accepted at edge N gives the following strobes:
  - psr_we/tbr_we high after edge N+1
  - rf_we(17) after N+2
  - rf_we(18) after N+3
  - redirect after N+4
  - busy falls after N+5
- Back-to-back traps: trap_req held high through VECTOR is re-sampled in IDLE, so a second trap starts no earlier than edge N+5.
- Ignored inputs:
  - trap_req while busy is ignored; upstream holds it.
  - Changes on tt_in, pc_in, npc_in and cwp_in after acceptance are ignored.
- Boundary values:
  - CWP wrap: cwp_in=0 gives NWINDOWS-1.
  - tt=8'h00 and tt=8'hFF are both legal and produce no special case.
- Held outputs: tbr_out, cwp_out and ps_out hold their last written value until the next trap or reset.

Test Plan:
- Reset mid-sequence: assert rst_n=0 while in SAVE1 -> all strobes 0 immediately; state IDLE; next trap_req runs a full 5-cycle sequence.
- Basic trap: tba_in=20'h40000, tt_in=8'h05, pc_in=32'h100, npc_in=32'h104, cwp_in=3, psr_s=0, psr_et=1, pulse trap_req -> expected strobes:
  - N+1: psr_we with cwp_out=2, ps_out=0, s_out=1, et_out=0; tbr_we with tbr_out=32'h40000050
  - N+2: rf_we, addr 17, data 32'h100
  - N+3: rf_we, addr 18, data 32'h104
  - N+4: redirect with redirect_pc=32'h40000050
- CWP wrap: cwp_in=0, NWINDOWS=8 -> cwp_out=7.
- Error mode: psr_et=0, trap_req=1 -> error_mode=1 after one edge; no strobes ever; holds through further trap_req until rst_n=0.
- Busy ignore: second trap_req with tt_in=8'h2A during SAVE1 -> no effect; tbr_out stays 32'h40000050; exactly one redirect.
- Back-to-back: trap_req held high across two traps -> second psr_we exactly 5 cycles after the first; cwp decrements twice (3->2->1).
